// File: rtl/gate_chk_pkg.sv
// Shared types, bit positions and the gate truth function used by the sweep checker.
// The seven-bit gate vector is ordered {nor, nand, xnor, xor, not a, or, and}.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int GATE_W      = 7;

    localparam int AND_B  = 0;
    localparam int OR_B   = 1;
    localparam int NOT_B  = 2;
    localparam int XOR_B  = 3;
    localparam int XNOR_B = 4;
    localparam int NAND_B = 5;
    localparam int NOR_B  = 6;

    function automatic logic [GATE_W-1:0] gate_expect(input logic a, input logic b);
        logic [GATE_W-1:0] y;
        y         = '0;
        y[AND_B]  = a & b;
        y[OR_B]   = a | b;
        y[NOT_B]  = ~a;
        y[XOR_B]  = a ^ b;
        y[XNOR_B] = ~(a ^ b);
        y[NAND_B] = ~(a & b);
        y[NOR_B]  = ~(a | b);
        return y;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_ref.sv
// Combinational golden model of the two-input gate block.
// Thin wrapper so the truth function can also be instantiated on its own.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic              i_a,
    input  logic              i_b,
    output logic [GATE_W-1:0] o_expect
);

    assign o_expect = gate_expect(i_a, i_b);

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives a/b through all four input vectors, waits a programmable settle time,
// then compares the gate block outputs against the golden model.
//
// state  | meaning
// IDLE   | waiting for start; status from the last sweep is held
// SETTLE | vector driven, counting down the settle window
// SAMPLE | compare y_in against expected, then advance or finish
// DONE   | one-cycle done pulse, operands returned to 0
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [6:0]       y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec,
    output logic [6:0]       fail_bits
);

    localparam logic [7:0]       CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [1:0]       LAST_IDX   = 2'(NUM_VECTORS - 1);

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [7:0]       r_cnt;
    logic             r_a;
    logic             r_b;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_count;
    logic [3:0]       r_fail_vec;
    logic [6:0]       r_fail_bits;

    state_t           w_state_nxt;
    logic [1:0]       w_idx_nxt;
    logic [7:0]       w_cnt_nxt;
    logic             w_a_nxt;
    logic             w_b_nxt;
    logic             w_pass_nxt;
    logic [ERR_W-1:0] w_err_count_nxt;
    logic [3:0]       w_fail_vec_nxt;
    logic [6:0]       w_fail_bits_nxt;

    logic [6:0]       w_expect;
    logic [6:0]       w_mism;
    logic [1:0]       w_idx_inc;

    // Expected values come from the registered operands, i.e. what the gate block sees.
    gate_ref_model u_ref (
        .i_a      (r_a),
        .i_b      (r_b),
        .o_expect (w_expect)
    );

    assign w_mism    = y_in ^ w_expect;
    assign w_idx_inc = r_idx + 2'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_pass_nxt      = r_pass;
        w_err_count_nxt = r_err_count;
        w_fail_vec_nxt  = r_fail_vec;
        w_fail_bits_nxt = r_fail_bits;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt     = SETTLE;
                    w_idx_nxt       = 2'd0;
                    w_a_nxt         = 1'b0;
                    w_b_nxt         = 1'b0;
                    w_cnt_nxt       = CNT_RELOAD;
                    w_pass_nxt      = 1'b0;
                    w_err_count_nxt = '0;
                    w_fail_vec_nxt  = '0;
                    w_fail_bits_nxt = '0;
                end
            end

            SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end

            SAMPLE: begin
                if (w_mism != 7'd0) begin
                    w_fail_vec_nxt[r_idx] = 1'b1;
                    w_fail_bits_nxt       = r_fail_bits | w_mism;
                    if (r_err_count != ERR_MAX) begin
                        w_err_count_nxt = r_err_count + ERR_W'(1);
                    end
                end
                if (r_idx == LAST_IDX) begin
                    // Pass is resolved here so it is already valid during the done pulse.
                    w_state_nxt = DONE;
                    w_pass_nxt  = (w_fail_vec_nxt == 4'd0);
                end else begin
                    w_state_nxt = SETTLE;
                    w_idx_nxt   = w_idx_inc;
                    w_a_nxt     = w_idx_inc[1];
                    w_b_nxt     = w_idx_inc[0];
                    w_cnt_nxt   = CNT_RELOAD;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
                w_a_nxt     = 1'b0;
                w_b_nxt     = 1'b0;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= 8'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_vec  <= 4'd0;
            r_fail_bits <= 7'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_pass      <= w_pass_nxt;
            r_err_count <= w_err_count_nxt;
            r_fail_vec  <= w_fail_vec_nxt;
            r_fail_bits <= w_fail_bits_nxt;
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_vec  = r_fail_vec;
    assign fail_bits = r_fail_bits;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three builds (default, ERR_W=2, SETTLE_CYCLES=1)
// share clock, reset and start, each fed by a modelled gate block with injectable faults.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;

    logic       a_m, b_m, busy_m, done_m, pass_m;
    logic [6:0] y_m, fb_m;
    logic [3:0] err_m, fv_m;

    logic       a_w, b_w, busy_w, done_w, pass_w;
    logic [6:0] y_w, fb_w;
    logic [1:0] err_w;
    logic [3:0] fv_w;

    logic       a_s, b_s, busy_s, done_s, pass_s;
    logic [6:0] y_s, fb_s;
    logic [3:0] err_s, fv_s;

    logic [6:0] fault_mask [4];
    int         dly_sel;
    logic [6:0] d1, d2;

    int n_pass;
    int n_total;

    int         done_cyc_m, done_n_m, done_cyc_s, done_n_s;
    logic       pass_done_m, pass_done_s;
    logic       busy_log [25];
    logic [1:0] ab_log [25];
    logic [3:0] fv_c1;
    logic [3:0] err_c1;

    gate_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_m), .b(b_m), .y_in(y_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m),
        .fail_vec(fv_m), .fail_bits(fb_m)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_w), .b(b_w), .y_in(y_w),
        .busy(busy_w), .done(done_w), .pass(pass_w), .err_count(err_w),
        .fail_vec(fv_w), .fail_bits(fb_w)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_s), .b(b_s), .y_in(y_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .fail_vec(fv_s), .fail_bits(fb_s)
    );

    // Truth table by counting ones among the operands.
    function automatic logic [6:0] gate_truth(input logic ia, input logic ib);
        int s;
        logic [6:0] y;
        s    = int'(ia) + int'(ib);
        y[0] = (s == 2);
        y[1] = (s >= 1);
        y[2] = (ia == 1'b0);
        y[3] = (s == 1);
        y[4] = (s != 1);
        y[5] = (s != 2);
        y[6] = (s == 0);
        return y;
    endfunction

    assign y_m = gate_truth(a_m, b_m) ^ fault_mask[{a_m, b_m}];
    assign y_w = gate_truth(a_w, b_w) ^ fault_mask[{a_w, b_w}];

    always @(posedge clk) begin
        d1 <= gate_truth(a_s, b_s);
        d2 <= d1;
    end

    always_comb begin
        y_s = gate_truth(a_s, b_s);
        if (dly_sel == 1) y_s = d1;
        else if (dly_sel == 2) y_s = d2;
    end

    function automatic logic [3:0] exp_fv();
        logic [3:0] r;
        for (int v = 0; v < 4; v++) r[v] = (fault_mask[v] != 7'd0);
        return r;
    endfunction

    function automatic logic [6:0] exp_fb();
        logic [6:0] r;
        r = 7'd0;
        for (int v = 0; v < 4; v++) r = r | fault_mask[v];
        return r;
    endfunction

    function automatic int exp_err(input int max_v);
        int c;
        c = 0;
        for (int v = 0; v < 4; v++) if (fault_mask[v] != 7'd0) c++;
        return (c > max_v) ? max_v : c;
    endfunction

    task automatic set_mask_none();
        for (int v = 0; v < 4; v++) fault_mask[v] = 7'd0;
    endtask

    task automatic set_mask_xor_stuck0();
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            vv = 2'(v);
            fault_mask[v] = gate_truth(vv[1], vv[0]) & 7'b0001000;
        end
    endtask

    // Start edge ends cycle 0; cycle n is sampled at the negedge after the n-th edge.
    task automatic run_sweep(input int pulse_at);
        done_n_m = 0; done_cyc_m = -1; done_n_s = 0; done_cyc_s = -1;
        pass_done_m = 1'bx; pass_done_s = 1'bx;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            start = (n == pulse_at);
            ab_log[n]   = {a_m, b_m};
            busy_log[n] = busy_m;
            if (n == 1) begin
                fv_c1  = fv_m;
                err_c1 = err_m;
            end
            if (done_m) begin done_n_m++; done_cyc_m = n; pass_done_m = pass_m; end
            if (done_s) begin done_n_s++; done_cyc_s = n; pass_done_s = pass_s; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({a_m, b_m, busy_m, done_m, pass_m} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {a_m, b_m, busy_m, done_m, pass_m});
        else n_pass++;
        n_total++;
        if ({err_m, fv_m, fb_m} !== 15'd0)
            $display("FAIL reset_status: got %h expected 0", {err_m, fv_m, fb_m});
        else n_pass++;
    endtask

    task automatic test_clean_sweep();
        int bad_ab, bad_busy;
        set_mask_none();
        dly_sel = 0;
        n_total++;
        if (busy_m !== 1'b0) $display("FAIL busy_before_start: got %b expected 0", busy_m);
        else n_pass++;
        run_sweep(0);
        bad_ab = 0; bad_busy = 0;
        for (int n = 1; n <= 12; n++) begin
            if (ab_log[n] !== 2'((n - 1) / 3)) bad_ab++;
            if (busy_log[n] !== 1'b1) bad_busy++;
        end
        n_total++;
        if (bad_ab != 0) $display("FAIL ab_sequence: got %0d bad cycles expected 0", bad_ab);
        else n_pass++;
        n_total++;
        if (bad_busy != 0 || busy_log[14] !== 1'b0)
            $display("FAIL busy_window: got %0d bad, busy14=%b expected 0 bad, busy14=0", bad_busy, busy_log[14]);
        else n_pass++;
        n_total++;
        if (done_cyc_m != 13 || done_n_m != 1)
            $display("FAIL clean_done: got cycle %0d count %0d expected cycle 13 count 1", done_cyc_m, done_n_m);
        else n_pass++;
        n_total++;
        if (pass_done_m !== 1'b1 || pass_m !== 1'b1)
            $display("FAIL clean_pass: got %b/%b expected 1/1", pass_done_m, pass_m);
        else n_pass++;
        n_total++;
        if ({err_m, fv_m, fb_m} !== 15'd0)
            $display("FAIL clean_status: got %h expected 0", {err_m, fv_m, fb_m});
        else n_pass++;
        n_total++;
        if (done_cyc_s != 9 || pass_done_s !== 1'b1)
            $display("FAIL s1_done: got cycle %0d pass %b expected cycle 9 pass 1", done_cyc_s, pass_done_s);
        else n_pass++;
    endtask

    task automatic test_xor_stuck();
        set_mask_xor_stuck0();
        run_sweep(0);
        n_total++;
        if (fv_m !== 4'b0110) $display("FAIL xor_fail_vec: got %b expected 0110", fv_m);
        else n_pass++;
        n_total++;
        if (err_m !== 4'd2) $display("FAIL xor_err_count: got %0d expected 2", err_m);
        else n_pass++;
        n_total++;
        if (fb_m !== 7'b0001000) $display("FAIL xor_fail_bits: got %b expected 0001000", fb_m);
        else n_pass++;
        n_total++;
        if (pass_done_m !== 1'b0 || pass_m !== 1'b0)
            $display("FAIL xor_pass: got %b/%b expected 0/0", pass_done_m, pass_m);
        else n_pass++;
    endtask

    task automatic test_not_inverted();
        for (int v = 0; v < 4; v++) fault_mask[v] = 7'b0000100;
        run_sweep(0);
        n_total++;
        if ({fv_m, err_m, fb_m} !== {4'b1111, 4'd4, 7'b0000100})
            $display("FAIL not_status: got fv=%b err=%0d fb=%b expected fv=1111 err=4 fb=0000100", fv_m, err_m, fb_m);
        else n_pass++;
        n_total++;
        if (pass_m !== 1'b0) $display("FAIL not_pass: got %b expected 0", pass_m);
        else n_pass++;
        n_total++;
        if (err_w !== 2'd3 || fv_w !== 4'b1111)
            $display("FAIL w2_saturate: got err=%0d fv=%b expected err=3 fv=1111", err_w, fv_w);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int v = 0; v < 4; v++)
                fault_mask[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
            run_sweep(0);
            n_total++;
            if (fv_m !== exp_fv()) $display("FAIL rand_fail_vec[%0d]: got %b expected %b", it, fv_m, exp_fv());
            else n_pass++;
            n_total++;
            if (fb_m !== exp_fb()) $display("FAIL rand_fail_bits[%0d]: got %b expected %b", it, fb_m, exp_fb());
            else n_pass++;
            n_total++;
            if (err_m !== 4'(exp_err(15))) $display("FAIL rand_err[%0d]: got %0d expected %0d", it, err_m, exp_err(15));
            else n_pass++;
            n_total++;
            if (pass_done_m !== (exp_fv() == 4'd0))
                $display("FAIL rand_pass[%0d]: got %b expected %b", it, pass_done_m, (exp_fv() == 4'd0));
            else n_pass++;
            n_total++;
            if (err_w !== 2'(exp_err(3))) $display("FAIL rand_err_w2[%0d]: got %0d expected %0d", it, err_w, exp_err(3));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        set_mask_xor_stuck0();
        run_sweep(5);
        n_total++;
        if (done_cyc_m != 13 || done_n_m != 1)
            $display("FAIL busy_start_done: got cycle %0d count %0d expected cycle 13 count 1", done_cyc_m, done_n_m);
        else n_pass++;
        n_total++;
        if (fv_m !== 4'b0110) $display("FAIL busy_start_status: got %b expected 0110", fv_m);
        else n_pass++;
        set_mask_none();
        run_sweep(0);
        n_total++;
        if (fv_c1 !== 4'd0 || err_c1 !== 4'd0)
            $display("FAIL restart_clear: got fv=%b err=%0d expected fv=0000 err=0", fv_c1, err_c1);
        else n_pass++;
        n_total++;
        if (pass_m !== 1'b1 || done_cyc_m != 13)
            $display("FAIL restart_pass: got pass %b cycle %0d expected pass 1 cycle 13", pass_m, done_cyc_m);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] fv_pre;
        int         done_seen, busy_seen;
        set_mask_xor_stuck0();
        done_seen = 0; busy_seen = 0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_m) done_seen++;
        end
        fv_pre = fv_m;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (fv_pre !== 4'b0010) $display("FAIL mid_prereset_fv: got %b expected 0010", fv_pre);
        else n_pass++;
        n_total++;
        if ({a_m, b_m, busy_m, done_m, pass_m, err_m, fv_m, fb_m} !== 20'd0)
            $display("FAIL mid_reset_async: got %h expected 0", {a_m, b_m, busy_m, done_m, pass_m, err_m, fv_m, fb_m});
        else n_pass++;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done_m) done_seen++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done_m) done_seen++;
            if (busy_m) busy_seen++;
        end
        n_total++;
        if (done_seen != 0 || busy_seen != 0)
            $display("FAIL mid_reset_quiet: got done %0d busy %0d expected 0 0", done_seen, busy_seen);
        else n_pass++;
        set_mask_none();
        run_sweep(0);
        n_total++;
        if (done_cyc_m != 13 || pass_done_m !== 1'b1)
            $display("FAIL post_reset_sweep: got cycle %0d pass %b expected cycle 13 pass 1", done_cyc_m, pass_done_m);
        else n_pass++;
    endtask

    task automatic test_settle_window();
        logic [3:0] exp_s;
        set_mask_none();
        dly_sel = 2;
        // A two-cycle lag means each sample sees the previous vector (vector 0 sees idle 00).
        for (int k = 0; k < 4; k++) begin
            logic [1:0] cur, prv;
            cur = 2'(k);
            prv = (k == 0) ? 2'd0 : 2'(k - 1);
            exp_s[k] = (gate_truth(cur[1], cur[0]) != gate_truth(prv[1], prv[0]));
        end
        run_sweep(0);
        n_total++;
        if (fv_s !== exp_s || pass_done_s !== 1'b0)
            $display("FAIL s1_late_y: got fv=%b pass=%b expected fv=%b pass=0", fv_s, pass_done_s, exp_s);
        else n_pass++;
        n_total++;
        if (done_cyc_s != 9) $display("FAIL s1_late_done: got cycle %0d expected 9", done_cyc_s);
        else n_pass++;
        dly_sel = 1;
        run_sweep(0);
        n_total++;
        if (pass_done_s !== 1'b1 || fv_s !== 4'd0)
            $display("FAIL s1_lag1: got pass=%b fv=%b expected pass=1 fv=0000", pass_done_s, fv_s);
        else n_pass++;
        dly_sel = 0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        dly_sel = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        for (int v = 0; v < 4; v++) fault_mask[v] = 7'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_clean_sweep();
        test_xor_stuck();
        test_not_inverted();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_settle_window();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
